seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider: the subtractive inverse of the datapath's lookahead adders.
- Produces quotient and remainder of WIDTH-bit operands, one bit per clock, using a (WIDTH+1)-bit trial subtraction.
- Sits beside the ALU as a start/done coprocessor for the SLC3 datapath and microcode.
- The control FSM stalls until Done.

---
 rtl/seq_divider.sv | 74 +++++++
 tb/tb_seq_divider.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Quotient,
  output logic [WIDTH-1:0] Remainder,
  output logic             DivByZero
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d, d_q, d_d, r_sh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic dbz_q, dbz_d;
  logic [WIDTH:0] trial;
  assign Busy = state_q != IDLE;
  assign Done = state_q == DONE;
  assign Quotient = q_q;
  assign Remainder = r_q;
  assign DivByZero = dbz_q;
  // next-state: capture on Start in IDLE, one restoring step per RUN cycle
  always_comb begin
    state_d = state_q;
    q_d = q_q;
    r_d = r_q;
    d_d = d_q;
    cnt_d = cnt_q;
    dbz_d = dbz_q;
    r_sh = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
    trial = {1'b0, r_sh} - {1'b0, d_q};
    case (state_q)
      IDLE: if (Start) begin
        d_d = Divisor;
        cnt_d = '0;
        dbz_d = Divisor == '0;
        q_d = Divisor == '0 ? '1 : Dividend;
        r_d = Divisor == '0 ? Dividend : '0;
        state_d = Divisor == '0 ? DONE : RUN;
      end
      RUN: begin
        r_d = trial[WIDTH] ? r_sh : trial[WIDTH-1:0];
        q_d = {q_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(WIDTH - 1) ? DONE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous active-low clear of everything
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      q_q <= '0;
      r_q <= '0;
      d_q <= '0;
      cnt_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q <= q_d;
      r_q <= r_d;
      d_q <= d_d;
      cnt_q <= cnt_d;
      dbz_q <= dbz_d;
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed and random checks of seq_divider against arithmetic reference
module tb_seq_divider;
  localparam int W = 16;
  logic Clk = 1'b0, Reset_n = 1'b0, Start = 1'b0;
  logic [W-1:0] Dividend = '0, Divisor = '0;
  logic Busy, Done, DivByZero;
  logic [W-1:0] Quotient, Remainder;
  int total = 0, bad = 0;
  seq_divider #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Dividend(Dividend), .Divisor(Divisor),
    .Busy(Busy), .Done(Done), .Quotient(Quotient), .Remainder(Remainder), .DivByZero(DivByZero)
  );
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(input bit drop, output int n);
    n = 0;
    do begin
      @(posedge Clk);
      #1;
      n++;
      if (drop) Start = 1'b0;
    end while (!Done && n < 40);
  endtask
  task automatic check_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int n);
    logic [31:0] eq, er;
    eq = b == 0 ? 32'hFFFF : 32'(a) / 32'(b);
    er = b == 0 ? 32'(a) : 32'(a) % 32'(b);
    chk({tag, "_lat"}, n, b == 0 ? 1 : W + 1);
    chk({tag, "_done"}, Done, 1);
    chk({tag, "_busy"}, Busy, 1);
    chk({tag, "_q"}, Quotient, eq);
    chk({tag, "_r"}, Remainder, er);
    chk({tag, "_dbz"}, DivByZero, b == 0);
    if (b != 0) begin
      chk({tag, "_inv"}, 32'(Quotient) * 32'(b) + 32'(Remainder), 32'(a));
      chk({tag, "_rlt"}, Remainder < b, 1);
    end
  endtask
  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    logic [W-1:0] hq, hr;
    Dividend = a;
    Divisor = b;
    Start = 1'b1;
    wait_done(1, n);
    Dividend = $urandom;
    Divisor = $urandom;
    check_result(tag, a, b, n);
    hq = Quotient;
    hr = Remainder;
    @(posedge Clk);
    #1;
    chk({tag, "_idle_done"}, Done, 0);
    chk({tag, "_idle_busy"}, Busy, 0);
    chk({tag, "_hold"}, {Quotient, Remainder}, {hq, hr});
  endtask
  initial begin
    int n, pulses;
    logic [W-1:0] a, b;
    repeat (2) @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    chk("rst_q", Quotient, 0);
    chk("rst_r", Remainder, 0);
    chk("rst_dbz", DivByZero, 0);
    run_div("d100_7", 16'd100, 16'd7);
    chk("d100_7_q14", Quotient, 14);
    chk("d100_7_r2", Remainder, 2);
    run_div("dffff_1", 16'hFFFF, 16'd1);
    run_div("d3_10", 16'd3, 16'd10);
    run_div("dffff_ffff", 16'hFFFF, 16'hFFFF);
    run_div("d5_0", 16'd5, 16'd0);
    run_div("d9_3", 16'd9, 16'd3);
    Dividend = 16'd100;
    Divisor = 16'd7;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Dividend = 16'd50;
    Divisor = 16'd5;
    wait_done(0, n);
    check_result("held1", 16'd100, 16'd7, n + 1);
    @(posedge Clk);
    #1;
    chk("held_idle_busy", Busy, 0);
    chk("held_idle_done", Done, 0);
    wait_done(1, n);
    check_result("held2", 16'd50, 16'd5, n);
    @(posedge Clk);
    #1;
    Dividend = 16'd100;
    Divisor = 16'd7;
    Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    repeat (7) @(posedge Clk);
    #1;
    chk("mid_busy", Busy, 1);
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    chk("abort_busy", Busy, 0);
    chk("abort_done", Done, 0);
    chk("abort_q", Quotient, 0);
    chk("abort_r", Remainder, 0);
    chk("abort_dbz", DivByZero, 0);
    pulses = 0;
    repeat (20) begin
      @(posedge Clk);
      #1;
      pulses += int'(Done);
    end
    chk("abort_no_done", pulses, 0);
    run_div("d9_2", 16'd9, 16'd2);
    chk("d9_2_q4", Quotient, 4);
    chk("d9_2_r1", Remainder, 1);
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = 16'($urandom_range(1, 15));
        2: b = a;
        default: b = $urandom;
      endcase
      run_div("rnd", a, b);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
